// File: rtl/gshare_update_sched.sv
// Write sequencer for a single-write-port gshare PHT: init/flush sweep, buffered
// dual-slot counter updates drained one per cycle, and mispredict GHSR restore.
module gshare_update_sched #(
    parameter int PHT_W  = 8,
    parameter int GHSR_W = 8,
    parameter int QDEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush_req,
    input  logic                         exe0_valid,
    input  logic                         exe1_valid,
    input  logic                         exe0_is_bj,
    input  logic                         exe1_is_bj,
    input  logic                         exe0_taken,
    input  logic                         exe1_taken,
    input  logic                         exe0_mispredict,
    input  logic                         exe1_mispredict,
    input  logic [31:0]                  exe0_pc,
    input  logic [31:0]                  exe1_pc,
    input  logic [GHSR_W-1:0]            exe0_ghsr,
    input  logic [GHSR_W-1:0]            exe1_ghsr,
    output logic                         upd_ready,
    output logic                         pht_wr_en,
    output logic                         pht_wr_init,
    output logic [PHT_W-1:0]             pht_wr_addr,
    output logic                         pht_wr_taken,
    output logic                         ghsr_restore_valid,
    output logic [GHSR_W-1:0]            ghsr_restore,
    output logic                         init_done,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

    localparam int CNT_W   = $clog2(QDEPTH+1);
    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int ENTRIES = 1 << PHT_W;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

    state_t             state, state_next;
    logic [PHT_W:0]     idx;
    logic               sweep_done;
    logic [PHT_W:0]     fifo_mem [QDEPTH];
    logic [PTR_W-1:0]   wptr, rptr;
    logic               q0_ok, q1_ok, m0, m1;
    logic               do_enq, do_deq;
    logic [1:0]         n_enq;
    logic [PHT_W:0]     ent0, ent1, first_ent;
    logic               unused_pc_bits;

    function automatic logic [PHT_W-1:0] gshare_hash(input logic [GHSR_W-1:0] g,
                                                     input logic [31:0] pc);
        return pc[PHT_W+1:2] ^ PHT_W'(g);
    endfunction

    assign unused_pc_bits = ^{exe0_pc[31:PHT_W+2], exe0_pc[1:0],
                              exe1_pc[31:PHT_W+2], exe1_pc[1:0]};

    // idx runs one past the last entry so the final write is visible before RUN
    assign sweep_done = (idx == (PHT_W+1)'(ENTRIES));
    assign init_done  = (state == ST_RUN);
    assign upd_ready  = (state == ST_RUN) && (q_count <= CNT_W'(QDEPTH-2));
    assign do_enq     = upd_ready && !flush_req;
    assign do_deq     = (state == ST_RUN) && !flush_req && (q_count != '0);

    always_comb begin
        q0_ok     = exe0_valid && exe0_is_bj;
        // a mispredicting exe0 makes exe1 wrong-path
        q1_ok     = exe1_valid && exe1_is_bj && !(q0_ok && exe0_mispredict);
        m0        = q0_ok && exe0_mispredict;
        m1        = exe1_valid && exe1_is_bj && exe1_mispredict;
        ent0      = {gshare_hash(exe0_ghsr, exe0_pc), exe0_taken};
        ent1      = {gshare_hash(exe1_ghsr, exe1_pc), exe1_taken};
        first_ent = q0_ok ? ent0 : ent1;
        n_enq     = 2'b00;
        if (do_enq)
            n_enq = {1'b0, q0_ok} + {1'b0, q1_ok};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_INIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (flush_req) state_next = ST_FLUSH;
            default: if (!flush_req && sweep_done) state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_enq != 2'b00) begin
            fifo_mem[wptr] <= first_ent;
            if (n_enq == 2'b10)
                fifo_mem[wptr + PTR_W'(1)] <= ent1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx          <= '0;
            wptr         <= '0;
            rptr         <= '0;
            q_count      <= '0;
            pht_wr_en    <= 1'b0;
            pht_wr_init  <= 1'b0;
            pht_wr_addr  <= '0;
            pht_wr_taken <= 1'b0;
        end else if (flush_req) begin
            idx         <= '0;
            wptr        <= '0;
            rptr        <= '0;
            q_count     <= '0;
            pht_wr_en   <= 1'b0;
            pht_wr_init <= 1'b0;
        end else if (state != ST_RUN) begin
            if (!sweep_done) begin
                pht_wr_en    <= 1'b1;
                pht_wr_init  <= 1'b1;
                pht_wr_addr  <= idx[PHT_W-1:0];
                pht_wr_taken <= 1'b0;
                idx          <= idx + 1'b1;
            end else begin
                pht_wr_en   <= 1'b0;
                pht_wr_init <= 1'b0;
                idx         <= '0;
            end
        end else begin
            // RUN: pop head onto the write port, push accepted EXE results
            pht_wr_en   <= do_deq;
            pht_wr_init <= 1'b0;
            if (do_deq) begin
                {pht_wr_addr, pht_wr_taken} <= fifo_mem[rptr];
                rptr <= rptr + PTR_W'(1);
            end
            wptr    <= wptr + PTR_W'(n_enq);
            q_count <= q_count + CNT_W'(n_enq) - CNT_W'(do_deq);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghsr_restore_valid <= 1'b0;
            ghsr_restore       <= '0;
        end else begin
            ghsr_restore_valid <= m0 || m1;
            if (m0)
                ghsr_restore <= {exe0_ghsr[GHSR_W-2:0], exe0_taken};
            else if (m1)
                ghsr_restore <= {exe1_ghsr[GHSR_W-2:0], exe1_taken};
        end
    end

endmodule

// File: tb/tb_gshare_update_sched.sv
// Directed self-checking bench for gshare_update_sched (PHT_W=8, GHSR_W=8, QDEPTH=4).
module tb_gshare_update_sched;

    localparam int PHT_W   = 8;
    localparam int GHSR_W  = 8;
    localparam int QDEPTH  = 4;
    localparam int ENTRIES = 256;

    logic              clk = 1'b0;
    logic              reset_n, flush_req;
    logic              exe0_valid, exe1_valid, exe0_is_bj, exe1_is_bj;
    logic              exe0_taken, exe1_taken, exe0_mispredict, exe1_mispredict;
    logic [31:0]       exe0_pc, exe1_pc;
    logic [7:0]        exe0_ghsr, exe1_ghsr;
    logic              upd_ready, pht_wr_en, pht_wr_init, pht_wr_taken;
    logic [7:0]        pht_wr_addr;
    logic              ghsr_restore_valid, init_done;
    logic [7:0]        ghsr_restore;
    logic [2:0]        q_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    gshare_update_sched #(.PHT_W(PHT_W), .GHSR_W(GHSR_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .flush_req(flush_req),
        .exe0_valid(exe0_valid), .exe1_valid(exe1_valid),
        .exe0_is_bj(exe0_is_bj), .exe1_is_bj(exe1_is_bj),
        .exe0_taken(exe0_taken), .exe1_taken(exe1_taken),
        .exe0_mispredict(exe0_mispredict), .exe1_mispredict(exe1_mispredict),
        .exe0_pc(exe0_pc), .exe1_pc(exe1_pc),
        .exe0_ghsr(exe0_ghsr), .exe1_ghsr(exe1_ghsr),
        .upd_ready(upd_ready), .pht_wr_en(pht_wr_en), .pht_wr_init(pht_wr_init),
        .pht_wr_addr(pht_wr_addr), .pht_wr_taken(pht_wr_taken),
        .ghsr_restore_valid(ghsr_restore_valid), .ghsr_restore(ghsr_restore),
        .init_done(init_done), .q_count(q_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [7:0] ref_hash(input logic [7:0] g, input logic [31:0] pc);
        return pc[9:2] ^ g;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exe;
        exe0_valid = 0; exe1_valid = 0; exe0_is_bj = 0; exe1_is_bj = 0;
        exe0_taken = 0; exe1_taken = 0; exe0_mispredict = 0; exe1_mispredict = 0;
        exe0_pc = '0; exe1_pc = '0; exe0_ghsr = '0; exe1_ghsr = '0;
    endtask

    task automatic drive_pair(input int p);
        logic [7:0] g;
        g = 8'(p * 3);
        exe0_valid = 1; exe0_is_bj = 1; exe0_mispredict = 0;
        exe1_valid = 1; exe1_is_bj = 1; exe1_mispredict = 0;
        exe0_pc = 32'h1000 + 32'(p * 8); exe0_ghsr = g;  exe0_taken = p[0];
        exe1_pc = 32'h1004 + 32'(p * 8); exe1_ghsr = ~g; exe1_taken = ~p[0];
    endtask

    function automatic logic [8:0] pair_ent(input int p, input int slot);
        logic [7:0] g;
        logic       t;
        g = 8'(p * 3);
        t = p[0];
        if (slot == 0)
            return {ref_hash(g, 32'h1000 + 32'(p * 8)), t};
        return {ref_hash(~g, 32'h1004 + 32'(p * 8)), ~t};
    endfunction

    // One step per entry; expects {wr_en,init,init_done,addr} = {1,1,0,i}
    task automatic sweep_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            step;
            chk("sweep", 32'({pht_wr_en, pht_wr_init, init_done, pht_wr_addr}),
                32'({3'b110, 8'(i)}));
        end
    endtask

    task automatic sweep_done_chk;
        step;
        chk("sweep_done", 32'({init_done, upd_ready, pht_wr_en, q_count}), 32'({3'b110, 3'd0}));
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [7:0] a, input logic t);
        chk(tag, 32'({pht_wr_en, pht_wr_init, pht_wr_en ? {pht_wr_addr, pht_wr_taken} : 9'd0}),
            32'({en, 1'b0, en ? {a, t} : 9'd0}));
    endtask

    logic [8:0] mq[$];
    logic [8:0] exp_e;
    logic       exp_en;
    int         p;

    initial begin
        reset_n = 0; flush_req = 0; clear_exe();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr", 32'({pht_wr_en, pht_wr_init, pht_wr_addr, pht_wr_taken}), 32'd0);
        chk("rst_ctl", 32'({upd_ready, init_done, q_count}), 32'd0);
        chk("rst_restore", 32'({ghsr_restore_valid, ghsr_restore}), 32'd0);

        // Initial sweep
        reset_n = 1;
        sweep_range(0, ENTRIES - 1);
        sweep_done_chk();

        // Single taken branch, two-cycle write latency
        exe0_valid = 1; exe0_is_bj = 1; exe0_taken = 1; exe0_pc = 32'h40; exe0_ghsr = 8'h00;
        step;
        clear_exe();
        chk("t2_q1", 32'(q_count), 32'd1);
        chk_wr("t2_nowr", 0, 8'h00, 0);
        step;
        chk_wr("t2_wr", 1, 8'h10, 1);
        chk("t2_q0", 32'(q_count), 32'd0);
        step;
        chk_wr("t2_idle", 0, 8'h00, 0);

        // exe0 mispredict squashes exe1
        exe0_valid = 1; exe0_is_bj = 1; exe0_mispredict = 1; exe0_taken = 0;
        exe0_pc = 32'h100; exe0_ghsr = 8'hA5;
        exe1_valid = 1; exe1_is_bj = 1; exe1_taken = 1; exe1_pc = 32'h200; exe1_ghsr = 8'h33;
        step;
        clear_exe();
        chk("t4_rv", 32'({ghsr_restore_valid, ghsr_restore}), 32'h14A);
        chk("t4_q", 32'(q_count), 32'd1);
        step;
        chk_wr("t4_wr", 1, 8'hE5, 0);
        chk("t4_rv_off", 32'(ghsr_restore_valid), 32'd0);
        step;
        chk_wr("t4_no_exe1", 0, 8'h00, 0);
        chk("t4_q0", 32'(q_count), 32'd0);

        // exe1 mispredict with exe0 correct: both enqueued in order
        exe0_valid = 1; exe0_is_bj = 1; exe0_taken = 1; exe0_pc = 32'h10; exe0_ghsr = 8'h0F;
        exe1_valid = 1; exe1_is_bj = 1; exe1_taken = 1; exe1_mispredict = 1;
        exe1_pc = 32'h24; exe1_ghsr = 8'h81;
        step;
        clear_exe();
        chk("t4b_rv", 32'({ghsr_restore_valid, ghsr_restore}), 32'h103);
        chk("t4b_q", 32'(q_count), 32'd2);
        step;
        chk_wr("t4b_wr0", 1, 8'h0B, 1);
        step;
        chk_wr("t4b_wr1", 1, 8'h88, 1);
        step;
        chk_wr("t4b_idle", 0, 8'h00, 0);

        // Non-branch in slot 0 is ignored; slot 1 alone is enqueued
        exe0_valid = 1; exe0_is_bj = 0; exe0_taken = 1; exe0_pc = 32'h300;
        exe1_valid = 1; exe1_is_bj = 1; exe1_taken = 0; exe1_pc = 32'h80; exe1_ghsr = 8'h02;
        step;
        clear_exe();
        chk("t4c_q", 32'(q_count), 32'd1);
        step;
        chk_wr("t4c_wr", 1, 8'h22, 0);
        step;

        // Back-pressure with both slots every cycle, modelled FIFO
        p = 0;
        for (int k = 0; k < 28; k++) begin
            if (p < 8) drive_pair(p);
            else clear_exe();
            chk("t3_ready", 32'(upd_ready), 32'(mq.size() <= QDEPTH - 2));
            exp_en = (mq.size() > 0);
            exp_e  = exp_en ? mq.pop_front() : 9'd0;
            if (p < 8 && (mq.size() + (exp_en ? 1 : 0)) <= QDEPTH - 2) begin
                mq.push_back(pair_ent(p, 0));
                mq.push_back(pair_ent(p, 1));
                p++;
            end
            step;
            chk("t3_q", 32'(q_count), 32'(mq.size()));
            chk_wr("t3_wr", exp_en, exp_e[8:1], exp_e[0]);
        end
        clear_exe();
        chk("t3_all_sent", 32'(p), 32'd8);

        // FIFO at 3 entries, then flush
        drive_pair(20);
        step;
        chk("t5_q2", 32'(q_count), 32'd2);
        step;
        chk("t5_q3", 32'({q_count, upd_ready}), 32'({3'd3, 1'b0}));
        flush_req = 1;
        step;
        flush_req = 0;
        clear_exe();
        chk("t5_flush", 32'({q_count, pht_wr_en, init_done, upd_ready}), 32'd0);
        sweep_range(0, ENTRIES - 1);
        sweep_done_chk();

        // Restore and flush in the same cycle, then reset mid-sweep at idx 17
        exe0_valid = 1; exe0_is_bj = 1; exe0_mispredict = 1; exe0_taken = 1; exe0_ghsr = 8'h01;
        flush_req = 1;
        step;
        flush_req = 0;
        clear_exe();
        chk("t6_rv_flush", 32'({ghsr_restore_valid, ghsr_restore, init_done, q_count}),
            32'({1'b1, 8'h03, 1'b0, 3'd0}));
        sweep_range(0, 17);
        reset_n = 0;
        #1;
        chk("t6_rst_wr", 32'({pht_wr_en, pht_wr_init, pht_wr_addr, pht_wr_taken}), 32'd0);
        chk("t6_rst_ctl", 32'({upd_ready, init_done, q_count, ghsr_restore_valid}), 32'd0);
        #1;
        reset_n = 1;
        sweep_range(0, ENTRIES - 1);
        sweep_done_chk();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
